varredura_display: RTL



---
 rtl/varredura_display_pkg.sv | 31 +++
 rtl/varredura_display_if.sv | 21 ++
 rtl/varredura_display_bcd_7seg.sv | 26 ++
 rtl/varredura_display.sv | 81 ++++++++
 4 files changed

// File: rtl/varredura_display_pkg.sv
// Shared constants and types for the scoreboard 7-segment scan driver.
// Digit enables and segments are active-low (common-anode display).
package pkg_display;

  localparam logic [3:0] DIG_PLACAR_A  = 4'b1101;
  localparam logic [3:0] DIG_PLACAR_B  = 4'b1110;
  localparam logic [3:0] DIG_CRONO_DEZ = 4'b0111;
  localparam logic [3:0] DIG_CRONO_UNI = 4'b1011;
  localparam logic [3:0] DIG_NENHUM    = 4'b1111;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;

  typedef struct packed {
    logic [3:0] placar_a;
    logic [3:0] placar_b;
    logic [3:0] crono_dez;
    logic [3:0] crono_uni;
  } digitos_t;

  // Anode wiring does not follow slot order, hence the explicit table.
  function automatic logic [3:0] dig_do_slot(input logic [1:0] slot);
    case (slot)
      2'd0:    return DIG_PLACAR_A;
      2'd1:    return DIG_PLACAR_B;
      2'd2:    return DIG_CRONO_DEZ;
      default: return DIG_CRONO_UNI;
    endcase
  endfunction

endpackage

// File: rtl/varredura_display_if.sv
// Display bus: four BCD digits plus load strobe in, scanned anodes/segments out.
interface varredura_display_if;
  logic [3:0] placar_a;
  logic [3:0] placar_b;
  logic [3:0] crono_dez;
  logic [3:0] crono_uni;
  logic       carregar;
  logic [3:0] digito;
  logic [6:0] segmentos;
  logic       inicio_quadro;

  modport master (
    output placar_a, placar_b, crono_dez, crono_uni, carregar,
    input  digito, segmentos, inicio_quadro
  );

  modport slave (
    input  placar_a, placar_b, crono_dez, crono_uni, carregar,
    output digito, segmentos, inicio_quadro
  );
endinterface

// File: rtl/varredura_display_bcd_7seg.sv
// BCD to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
// Non-decimal codes show a dash so bad data is visible on the panel.
module bcd_7seg
  import pkg_display::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/varredura_display.sv
// 4-digit multiplexed display driver: prescaled slot scan, per-slot blanking,
// and a per-frame shadow of the loaded digits so a frame never tears.
module varredura_display
  import pkg_display::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 240,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  varredura_display_if.slave  disp
);

  localparam int SLOT_CYCLES = CLK_HZ / SCAN_HZ;
  localparam int PRE_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(SLOT_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);

  logic [PRE_W-1:0] pre;
  logic [1:0]       slot;
  digitos_t         pendente, sombra, sombra_prox;
  logic             inicio, apagar;
  logic [3:0]       bcd_sel;
  logic [6:0]       seg_dec;
  logic [3:0]       digito_q;
  logic [6:0]       segmentos_q;
  logic             inicio_q;

  assign inicio = (pre == '0) && (slot == 2'd0);
  assign apagar = (pre < PRE_BLANK);

  // Decode from the value the shadow takes at this edge, so a zero-length
  // blanking window still shows the new frame's first digit correctly.
  always_comb sombra_prox = inicio ? pendente : sombra;

  always_comb begin
    case (slot)
      2'd0:    bcd_sel = sombra_prox.placar_a;
      2'd1:    bcd_sel = sombra_prox.placar_b;
      2'd2:    bcd_sel = sombra_prox.crono_dez;
      default: bcd_sel = sombra_prox.crono_uni;
    endcase
  end

  bcd_7seg u_bcd_7seg (
    .bcd (bcd_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre         <= '0;
      slot        <= 2'd0;
      pendente    <= '0;
      sombra      <= '0;
      digito_q    <= DIG_NENHUM;
      segmentos_q <= SEG_APAGADO;
      inicio_q    <= 1'b0;
    end else begin
      if (pre == PRE_MAX) begin
        pre  <= '0;
        slot <= slot + 2'd1;
      end else begin
        pre <= pre + PRE_W'(1);
      end
      // A load coinciding with the frame boundary lands in the next frame.
      if (disp.carregar)
        pendente <= '{disp.placar_a, disp.placar_b, disp.crono_dez, disp.crono_uni};
      sombra      <= sombra_prox;
      digito_q    <= apagar ? DIG_NENHUM  : dig_do_slot(slot);
      segmentos_q <= apagar ? SEG_APAGADO : seg_dec;
      inicio_q    <= inicio;
    end
  end

  assign disp.digito        = digito_q;
  assign disp.segmentos     = segmentos_q;
  assign disp.inicio_quadro = inicio_q;

endmodule
